// File: rtl/scan_timing_gen_pkg.sv
// scan_pkg: shared types and default timing for the raster scan generator.
// Holds the per-axis state enum, the default panel timing, line/frame total
// helpers and the range check used by the elaboration-time parameter guards.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FP     = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BP     = 2'd3
    } scan_state_e;

    // Phase counters and coordinates are this wide; every timing value must fit.
    localparam int PHASE_W = 10;

    localparam int DEF_CE_DIV     = 2;
    localparam int DEF_COL_ACTIVE = 300;
    localparam int DEF_COL_FP     = 8;
    localparam int DEF_COL_SYNC   = 32;
    localparam int DEF_COL_BP     = 40;
    localparam int DEF_ROW_ACTIVE = 480;
    localparam int DEF_ROW_FP     = 4;
    localparam int DEF_ROW_SYNC   = 4;
    localparam int DEF_ROW_BP     = 12;
    localparam int DEF_PIPE_DLY   = 3;

    // Total length of one axis period (ticks per line, or lines per frame).
    function automatic int axis_total(int len_active, int len_fp, int len_sync, int len_bp);
        return len_active + len_fp + len_sync + len_bp;
    endfunction

    localparam int DEF_LINE_TICKS  = axis_total(DEF_COL_ACTIVE, DEF_COL_FP, DEF_COL_SYNC, DEF_COL_BP);
    localparam int DEF_FRAME_LINES = axis_total(DEF_ROW_ACTIVE, DEF_ROW_FP, DEF_ROW_SYNC, DEF_ROW_BP);

    // True when a timing value is representable by a phase counter.
    function automatic bit timing_ok(int v);
        return (v >= 0) && (v < (1 << PHASE_W));
    endfunction

endpackage

// File: rtl/scan_timing_gen_if.sv
// scan_timing_gen_if: scan control input and raster timing outputs.
// master = the generator, slave = the consumer (pixel stage).
// FRAME_COUNT_EN adds the frame_count bus.
interface scan_timing_gen_if;

    logic                         scan_en;
    logic [scan_pkg::PHASE_W-1:0] current_print_row;
    logic [scan_pkg::PHASE_W-1:0] current_print_column;
    logic                         valid_array;
    logic                         pix_tick;
    logic                         hsync;
    logic                         vsync;
    logic                         pixel_de;
    logic                         frame_start;
`ifdef FRAME_COUNT_EN
    logic [15:0]                  frame_count;
`endif

    modport master (
        input  scan_en,
`ifdef FRAME_COUNT_EN
        output frame_count,
`endif
        output current_print_row,
        output current_print_column,
        output valid_array,
        output pix_tick,
        output hsync,
        output vsync,
        output pixel_de,
        output frame_start
    );

    modport slave (
        output scan_en,
`ifdef FRAME_COUNT_EN
        input  frame_count,
`endif
        input  current_print_row,
        input  current_print_column,
        input  valid_array,
        input  pix_tick,
        input  hsync,
        input  vsync,
        input  pixel_de,
        input  frame_start
    );

endinterface

// File: rtl/scan_timing_gen_axis_fsm.sv
// scan_axis_fsm: one scan axis cycling ACTIVE -> FP -> SYNC -> BP -> ACTIVE.
// The phase counter runs 0..len-1 in each state; zero-length states are
// skipped. wrap pulses on the advance that closes the period back to ACTIVE.
module scan_axis_fsm
    import scan_pkg::*;
#(
    parameter int LEN_ACTIVE = DEF_COL_ACTIVE,
    parameter int LEN_FP     = DEF_COL_FP,
    parameter int LEN_SYNC   = DEF_COL_SYNC,
    parameter int LEN_BP     = DEF_COL_BP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               advance,
    output scan_state_e        state,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap
);

    if (!(timing_ok(LEN_ACTIVE) && timing_ok(LEN_FP) && timing_ok(LEN_SYNC) &&
          timing_ok(LEN_BP) && (LEN_ACTIVE >= 1))) begin : g_bad_len
        $error("scan_axis_fsm: axis length out of range");
    end

    scan_state_e        state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               last;

    function automatic logic [PHASE_W-1:0] len_of(scan_state_e s);
        case (s)
            ST_ACTIVE: return PHASE_W'(LEN_ACTIVE);
            ST_FP:     return PHASE_W'(LEN_FP);
            ST_SYNC:   return PHASE_W'(LEN_SYNC);
            default:   return PHASE_W'(LEN_BP);
        endcase
    endfunction

    // Nearest following state in cycle order with a non-zero length.
    function automatic scan_state_e next_of(scan_state_e s);
        scan_state_e nxt;
        nxt = s;
        for (int i = 3; i >= 1; i--) begin
            if (len_of(scan_state_e'(2'(s) + 2'(i))) != '0)
                nxt = scan_state_e'(2'(s) + 2'(i));
        end
        return nxt;
    endfunction

    // State and phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACTIVE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next state/phase; wrap when the move lands at or before the current state.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wrap    = 1'b0;
        last    = (phase_q == len_of(state_q) - PHASE_W'(1));
        if (advance) begin
            if (last) begin
                state_d = next_of(state_q);
                phase_d = '0;
                wrap    = (2'(state_d) <= 2'(state_q));
            end else begin
                phase_d = phase_q + PHASE_W'(1);
            end
        end
    end

    assign state = state_q;
    assign phase = phase_q;

endmodule

// File: rtl/scan_timing_gen.sv
// scan_timing_gen: raster scan generator feeding the background pixel stage.
// A pixel-tick divider paces two axis FSMs; coordinates, valid, syncs and
// frame_start are registered on the tick; pixel_de is valid_array delayed by
// PIPE_DLY ticks to line up with the ROM pipeline output.
// Optional: define FRAME_COUNT_EN to add the 16-bit frame_count output.
module scan_timing_gen
    import scan_pkg::*;
#(
    parameter int   CE_DIV     = DEF_CE_DIV,
    parameter int   COL_ACTIVE = DEF_COL_ACTIVE,
    parameter int   COL_FP     = DEF_COL_FP,
    parameter int   COL_SYNC   = DEF_COL_SYNC,
    parameter int   COL_BP     = DEF_COL_BP,
    parameter int   ROW_ACTIVE = DEF_ROW_ACTIVE,
    parameter int   ROW_FP     = DEF_ROW_FP,
    parameter int   ROW_SYNC   = DEF_ROW_SYNC,
    parameter int   ROW_BP     = DEF_ROW_BP,
    parameter int   PIPE_DLY   = DEF_PIPE_DLY,
    parameter logic SYNC_POL   = 1'b0
) (
    input logic               clk,
    input logic               rst,
    scan_timing_gen_if.master bus
);

    if (!(timing_ok(CE_DIV) && (CE_DIV >= 1) && timing_ok(PIPE_DLY))) begin : g_bad_params
        $error("scan_timing_gen: CE_DIV or PIPE_DLY out of range");
    end

    localparam int               DIV_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic               div_wrap;
    logic               adv;
    scan_state_e        h_state, v_state;
    logic [PHASE_W-1:0] h_phase, v_phase;
    logic               h_wrap, v_wrap;
    logic               h_active, v_active;
    logic               at_origin;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign adv      = div_wrap && bus.scan_en;
    assign h_active = (h_state == ST_ACTIVE);
    assign v_active = (v_state == ST_ACTIVE);

    // Pixel tick divider; free-running regardless of scan_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt      <= '0;
            bus.pix_tick <= 1'b0;
        end else begin
            div_cnt      <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            bus.pix_tick <= div_wrap;
        end
    end

    scan_axis_fsm #(
        .LEN_ACTIVE (COL_ACTIVE),
        .LEN_FP     (COL_FP),
        .LEN_SYNC   (COL_SYNC),
        .LEN_BP     (COL_BP)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .advance (adv),
        .state   (h_state),
        .phase   (h_phase),
        .wrap    (h_wrap)
    );

    // The vertical axis steps once per line, when the horizontal axis wraps.
    scan_axis_fsm #(
        .LEN_ACTIVE (ROW_ACTIVE),
        .LEN_FP     (ROW_FP),
        .LEN_SYNC   (ROW_SYNC),
        .LEN_BP     (ROW_BP)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .advance (h_wrap),
        .state   (v_state),
        .phase   (v_phase),
        .wrap    (v_wrap)
    );

    // Tracks that both axes sit at ACTIVE phase 0 (after reset or a frame wrap).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            at_origin <= 1'b1;
        else if (adv)
            at_origin <= v_wrap;
    end

    // Registered coordinates, valid, syncs and frame pulse; all move on the same tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.current_print_column <= '0;
            bus.current_print_row    <= '0;
            bus.valid_array          <= 1'b0;
            bus.hsync                <= ~SYNC_POL;
            bus.vsync                <= ~SYNC_POL;
            bus.frame_start          <= 1'b0;
        end else begin
            bus.frame_start <= adv && at_origin;
            if (adv) begin
                bus.current_print_column <= h_active ? h_phase : PHASE_W'(COL_ACTIVE - 1);
                bus.current_print_row    <= v_active ? v_phase : PHASE_W'(ROW_ACTIVE - 1);
                bus.valid_array          <= h_active && v_active;
                bus.hsync                <= (h_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
                bus.vsync                <= (v_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    if (PIPE_DLY == 0) begin : g_de_bypass
        assign bus.pixel_de = bus.valid_array;
    end else begin : g_de_pipe
        logic [PIPE_DLY-1:0] de_p;

        // Delay line for valid_array, stepped by every pixel tick.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                de_p <= '0;
            else if (div_wrap)
                de_p <= PIPE_DLY'({de_p, bus.valid_array});
        end

        assign bus.pixel_de = de_p[PIPE_DLY-1];
    end

`ifdef FRAME_COUNT_EN
    // Frame counter for animation timing; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.frame_count <= '0;
        else if (adv && at_origin)
            bus.frame_count <= bus.frame_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_scan_timing_gen.sv
// tb_scan_timing_gen: scoreboard bench for scan_timing_gen.
// Horizontal timing uses the panel defaults; the vertical axis is shortened
// (20 active rows, 2 FP, 3 sync, zero-length BP) so a full frame fits in a short run.
module tb_scan_timing_gen;

    localparam int   CE_DIV      = 2;
    localparam int   COL_ACTIVE  = 300;
    localparam int   COL_FP      = 8;
    localparam int   COL_SYNC    = 32;
    localparam int   COL_BP      = 40;
    localparam int   ROW_ACTIVE  = 20;
    localparam int   ROW_FP      = 2;
    localparam int   ROW_SYNC    = 3;
    localparam int   ROW_BP      = 0;
    localparam int   PIPE_DLY    = 3;
    localparam logic SYNC_POL    = 1'b0;
    localparam int   LINE        = COL_ACTIVE + COL_FP + COL_SYNC + COL_BP;  // 380
    localparam int   FRAME_LINES = ROW_ACTIVE + ROW_FP + ROW_SYNC + ROW_BP;  // 25
    localparam int   FRAME_TICKS = LINE * FRAME_LINES;                       // 9500

    typedef struct packed {
        int         k;
        logic [9:0] row;
        logic [9:0] col;
        logic       valid;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       de;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   sb_k = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    scan_timing_gen_if bus();

    scan_timing_gen #(
        .CE_DIV(CE_DIV), .COL_ACTIVE(COL_ACTIVE), .COL_FP(COL_FP), .COL_SYNC(COL_SYNC),
        .COL_BP(COL_BP), .ROW_ACTIVE(ROW_ACTIVE), .ROW_FP(ROW_FP), .ROW_SYNC(ROW_SYNC),
        .ROW_BP(ROW_BP), .PIPE_DLY(PIPE_DLY), .SYNC_POL(SYNC_POL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic model_valid(int k);
        int h, l;
        if (k < 0) return 1'b0;
        h = k % LINE;
        l = (k / LINE) % FRAME_LINES;
        return (h < COL_ACTIVE) && (l < ROW_ACTIVE);
    endfunction

    // Expected outputs on scanning tick k counted from reset release.
    function automatic exp_t model(int k);
        exp_t e;
        int   h, l;
        h       = k % LINE;
        l       = (k / LINE) % FRAME_LINES;
        e.k     = k;
        e.col   = (h < COL_ACTIVE) ? 10'(h) : 10'(COL_ACTIVE - 1);
        e.row   = (l < ROW_ACTIVE) ? 10'(l) : 10'(ROW_ACTIVE - 1);
        e.valid = model_valid(k);
        e.hs    = (h >= COL_ACTIVE + COL_FP && h < COL_ACTIVE + COL_FP + COL_SYNC) ? SYNC_POL : ~SYNC_POL;
        e.vs    = (l >= ROW_ACTIVE + ROW_FP && l < ROW_ACTIVE + ROW_FP + ROW_SYNC) ? SYNC_POL : ~SYNC_POL;
        e.fs    = ((k % FRAME_TICKS) == 0);
        e.de    = model_valid(k - PIPE_DLY);
        return e;
    endfunction

    // Monitor: each pix_tick pops one expected entry; between ticks frame_start must be low.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            checks++;
            if (bus.pix_tick) begin
                mon_e = sb_q.pop_front();
                if ({bus.current_print_row, bus.current_print_column, bus.valid_array, bus.hsync,
                     bus.vsync, bus.frame_start, bus.pixel_de} !==
                    {mon_e.row, mon_e.col, mon_e.valid, mon_e.hs, mon_e.vs, mon_e.fs, mon_e.de}) begin
                    failures++;
                    $display("FAIL scan_tick k=%0d got row=%0d col=%0d valid=%b hs=%b vs=%b fs=%b de=%b exp row=%0d col=%0d valid=%b hs=%b vs=%b fs=%b de=%b",
                             mon_e.k, bus.current_print_row, bus.current_print_column, bus.valid_array,
                             bus.hsync, bus.vsync, bus.frame_start, bus.pixel_de, mon_e.row, mon_e.col,
                             mon_e.valid, mon_e.hs, mon_e.vs, mon_e.fs, mon_e.de);
                end
            end else if (bus.frame_start !== 1'b0) begin
                failures++;
                $display("FAIL frame_start_width got=%b exp=0 between ticks", bus.frame_start);
            end
        end
    end

    // Push expected entries up to tick last_k, then wait (bounded) for the monitor to consume them.
    task automatic run_to(int last_k);
        int guard;
        for (int k = sb_k; k <= last_k; k++) sb_q.push_back(model(k));
        sb_k  = last_k + 1;
        guard = sb_q.size() * CE_DIV + 20;
        while (sb_q.size() > 0 && guard > 0) begin
            @(posedge clk); #2;
            guard--;
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain got=%0d entries left exp=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.scan_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({bus.current_print_row, bus.current_print_column, bus.valid_array, bus.pix_tick,
             bus.hsync, bus.vsync, bus.pixel_de, bus.frame_start} !==
            {10'd0, 10'd0, 1'b0, 1'b0, ~SYNC_POL, ~SYNC_POL, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got row=%0d col=%0d valid=%b tick=%b hs=%b vs=%b de=%b fs=%b",
                     bus.current_print_row, bus.current_print_column, bus.valid_array, bus.pix_tick,
                     bus.hsync, bus.vsync, bus.pixel_de, bus.frame_start);
        end
`ifdef FRAME_COUNT_EN
        checks++;
        if (bus.frame_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_frame_count got=%0d exp=0", bus.frame_count);
        end
`endif
    endtask

    // Release reset; tick on every 2nd clk, first tick shows (0,0), valid and a one-clk frame_start.
    task automatic test_first_tick();
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #2;
            checks++;
            if (bus.pix_tick !== ((c % CE_DIV) == 0)) begin
                failures++;
                $display("FAIL pix_tick_clk%0d got=%b exp=%b", c, bus.pix_tick, ((c % CE_DIV) == 0));
            end
            if (c == 2) begin
                checks++;
                if ({bus.current_print_row, bus.current_print_column, bus.valid_array, bus.frame_start,
                     bus.hsync, bus.vsync, bus.pixel_de} !==
                    {10'd0, 10'd0, 1'b1, 1'b1, ~SYNC_POL, ~SYNC_POL, 1'b0}) begin
                    failures++;
                    $display("FAIL first_tick got row=%0d col=%0d valid=%b fs=%b hs=%b vs=%b de=%b exp 0 0 1 1",
                             bus.current_print_row, bus.current_print_column, bus.valid_array,
                             bus.frame_start, bus.hsync, bus.vsync, bus.pixel_de);
                end
            end
            if (c == 3) begin
                checks++;
                if ({bus.frame_start, bus.current_print_column} !== {1'b0, 10'd0}) begin
                    failures++;
                    $display("FAIL first_tick_hold got fs=%b col=%0d exp fs=0 col=0",
                             bus.frame_start, bus.current_print_column);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.current_print_column !== 10'd1) begin
                    failures++;
                    $display("FAIL second_tick_col got=%0d exp=1", bus.current_print_column);
                end
            end
        end
        sb_k = 2;
    endtask

    task automatic test_line();
        run_to(LINE + 5);
    endtask

    // Freeze at row 10, column 150 for 20 clks; resume must continue at column 151.
    task automatic test_scan_en_freeze();
        int ticks_seen;
        run_to(10 * LINE + 150);
        bus.scan_en = 1'b0;
        ticks_seen  = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #2;
            if (bus.pix_tick) ticks_seen++;
            checks++;
            if ({bus.current_print_row, bus.current_print_column, bus.valid_array, bus.frame_start} !==
                {10'd10, 10'd150, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL freeze_hold clk=%0d got row=%0d col=%0d valid=%b fs=%b exp row=10 col=150 valid=1 fs=0",
                         c, bus.current_print_row, bus.current_print_column, bus.valid_array, bus.frame_start);
            end
        end
        checks++;
        if (ticks_seen != 20 / CE_DIV) begin
            failures++;
            $display("FAIL freeze_divider got=%0d ticks exp=%0d", ticks_seen, 20 / CE_DIV);
        end
        bus.scan_en = 1'b1;
        run_to(10 * LINE + 160);
    endtask

    // Rest of the frame, the end-of-frame double wrap, and the next frame_start.
    task automatic test_frame();
        run_to(FRAME_TICKS + LINE + 200);
    endtask

    // Asynchronous reset mid-line, then a clean restart from (0,0).
    task automatic test_async_reset();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.current_print_row, bus.current_print_column, bus.valid_array, bus.pix_tick,
             bus.hsync, bus.vsync, bus.pixel_de, bus.frame_start} !==
            {10'd0, 10'd0, 1'b0, 1'b0, ~SYNC_POL, ~SYNC_POL, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got row=%0d col=%0d valid=%b tick=%b hs=%b vs=%b de=%b fs=%b",
                     bus.current_print_row, bus.current_print_column, bus.valid_array, bus.pix_tick,
                     bus.hsync, bus.vsync, bus.pixel_de, bus.frame_start);
        end
        repeat (2) @(posedge clk);
        #2;
        test_first_tick();
        run_to(LINE + 20);
    endtask

`ifdef FRAME_COUNT_EN
    task automatic test_frame_count_wrap();
        force bus.frame_count = 16'hFFFF;
        @(posedge clk); #2;
        release bus.frame_count;
        run_to(FRAME_TICKS);
        checks++;
        if (bus.frame_count !== 16'd0) begin
            failures++;
            $display("FAIL frame_count_wrap got=%0d exp=0", bus.frame_count);
        end
    endtask
`endif

    initial begin
        bus.scan_en = 1'b1;
        test_reset();
        test_first_tick();
        test_line();
        test_scan_en_freeze();
        test_frame();
        test_async_reset();
`ifdef FRAME_COUNT_EN
        test_frame_count_wrap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
